// File: rtl/friscv_icache_pkg.sv
// Shared types and constants for the FRISCV instruction cache line filler.
// Holds the filler FSM encoding, AXI4 burst/response codes and geometry helpers.
package friscv_icache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_FILL  = 2'd2,
      ST_WRITE = 2'd3
   } state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   // Number of XLEN-wide beats needed to fill one cache line.
   function automatic int nb_beats(input int line_w, input int xlen);
      return line_w / xlen;
   endfunction

   // Number of byte-offset address bits inside one cache line.
   function automatic int offset_w(input int line_w);
      return $clog2(line_w / 8);
   endfunction

   function automatic int axi_size(input int xlen);
      return $clog2(xlen / 8);
   endfunction

endpackage

// File: rtl/friscv_icache_filler.sv
// Instruction cache line filler: turns a miss into one AXI4 INCR read burst,
// assembles the beats into a line and writes it to the cache storage.
module friscv_icache_filler
   import friscv_icache_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int ADDR_W       = 32,
   parameter int CACHE_LINE_W = 128,
   parameter int AXI_ID_W     = 8,
   parameter logic [AXI_ID_W-1:0] AXI_ID = 'h10
) (
   input  logic                    aclk,
   input  logic                    arst,
   input  logic                    srst,
   input  logic                    flush,
   input  logic                    miss_valid,
   output logic                    miss_ready,
   input  logic [ADDR_W-1:0]       miss_addr,
   output logic                    arvalid,
   input  logic                    arready,
   output logic [ADDR_W-1:0]       araddr,
   output logic [7:0]              arlen,
   output logic [2:0]              arsize,
   output logic [1:0]              arburst,
   output logic [AXI_ID_W-1:0]     arid,
   input  logic                    rvalid,
   output logic                    rready,
   input  logic [XLEN-1:0]         rdata,
   input  logic [1:0]              rresp,
   input  logic                    rlast,
   input  logic [AXI_ID_W-1:0]     rid,
   output logic                    cache_wen,
   output logic [ADDR_W-1:0]       cache_waddr,
   output logic [CACHE_LINE_W-1:0] cache_wdata,
   output logic                    fill_done,
   output logic                    fill_err
);

   localparam int NB_BEATS = nb_beats(CACHE_LINE_W, XLEN);
   localparam int OFFSET_W = offset_w(CACHE_LINE_W);
   localparam int CNT_W    = $clog2(NB_BEATS) + 1;
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFFSET_W) - 1);

   state_t                  r_state;
   logic [ADDR_W-1:0]       r_addr;
   logic [CACHE_LINE_W-1:0] r_line;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_err;
   logic                    r_flush;

   logic w_last_beat;
   logic w_beat_err;

   assign w_last_beat = (r_cnt == CNT_W'(NB_BEATS - 1));
   // A beat is faulty on a bad response, a foreign ID, or rlast out of place.
   assign w_beat_err  = (rresp != AXI_RESP_OKAY) || (rid != AXI_ID) || (rlast != w_last_beat);

   // NOTE: the line register is reset too, because cache_wdata must read zero after reset.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_line  <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_flush <= 1'b0;
      end else if (srst) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_line  <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_flush <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (miss_valid) begin
                  r_state <= ST_REQ;
                  r_addr  <= miss_addr & LINE_MASK;
                  r_cnt   <= '0;
                  r_err   <= 1'b0;
                  r_flush <= 1'b0;
               end
            end
            ST_REQ: begin
               if (flush) r_flush <= 1'b1;
               if (arready) r_state <= ST_FILL;
            end
            ST_FILL: begin
               // A flush only poisons the write; the burst is always drained.
               if (flush) r_flush <= 1'b1;
               if (rvalid) begin
                  for (int b = 0; b < NB_BEATS; b++) begin
                     if (r_cnt == CNT_W'(b)) r_line[b*XLEN +: XLEN] <= rdata;
                  end
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (w_beat_err) r_err <= 1'b1;
                  if (w_last_beat) r_state <= ST_WRITE;
               end
            end
            ST_WRITE: r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   assign miss_ready  = (r_state == ST_IDLE);
   assign arvalid     = (r_state == ST_REQ);
   assign araddr      = r_addr;
   assign arlen       = 8'(NB_BEATS - 1);
   assign arsize      = 3'(axi_size(XLEN));
   assign arburst     = AXI_BURST_INCR;
   assign arid        = AXI_ID;
   assign rready      = (r_state == ST_FILL);
   assign fill_done   = (r_state == ST_WRITE);
   assign fill_err    = (r_state == ST_WRITE) && r_err;
   assign cache_wen   = (r_state == ST_WRITE) && !r_err && !r_flush && !flush;
   assign cache_waddr = r_addr;
   assign cache_wdata = r_line;

endmodule

// File: tb/tb_friscv_icache_filler.sv
// Self-checking bench for friscv_icache_filler: directed scenarios plus randomized
// fills, each checked against a line-level reference built from the beats it sends.
module tb_friscv_icache_filler;

   localparam int XLEN   = 32;
   localparam int ADDR_W = 32;
   localparam int LINE_W = 128;
   localparam int IDW    = 8;
   localparam int NB     = LINE_W / XLEN;
   localparam logic [IDW-1:0] ID = 8'h10;

   logic              aclk, arst, srst, flush;
   logic              miss_valid, miss_ready;
   logic [ADDR_W-1:0] miss_addr;
   logic              arvalid, arready;
   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic [IDW-1:0]    arid;
   logic              rvalid, rready;
   logic [XLEN-1:0]   rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic [IDW-1:0]    rid;
   logic              cache_wen;
   logic [ADDR_W-1:0] cache_waddr;
   logic [LINE_W-1:0] cache_wdata;
   logic              fill_done, fill_err;

   int n_cmp;
   int n_mis;

   friscv_icache_filler #(
      .XLEN(XLEN), .ADDR_W(ADDR_W), .CACHE_LINE_W(LINE_W), .AXI_ID_W(IDW), .AXI_ID(ID)
   ) dut (
      .aclk(aclk), .arst(arst), .srst(srst), .flush(flush),
      .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
      .arsize(arsize), .arburst(arburst), .arid(arid),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .rlast(rlast), .rid(rid),
      .cache_wen(cache_wen), .cache_waddr(cache_waddr), .cache_wdata(cache_wdata),
      .fill_done(fill_done), .fill_err(fill_err)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_b(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      miss_valid = 1'b0;
      arready    = 1'b0;
      rvalid     = 1'b0;
      rdata      = '0;
      rresp      = 2'b00;
      rlast      = 1'b0;
      rid        = ID;
      flush      = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_b({tag, "_miss_ready"}, miss_ready, 1'b1);
      check_b({tag, "_arvalid"},    arvalid,    1'b0);
      check_b({tag, "_rready"},     rready,     1'b0);
      check_b({tag, "_cache_wen"},  cache_wen,  1'b0);
      check_b({tag, "_fill_done"},  fill_done,  1'b0);
      check_b({tag, "_fill_err"},   fill_err,   1'b0);
      check({tag, "_araddr"},       LINE_W'(araddr),      '0);
      check({tag, "_cache_waddr"},  LINE_W'(cache_waddr), '0);
      check({tag, "_cache_wdata"},  cache_wdata,          '0);
   endtask

   // One complete fill from the memory side. Beat indices are 0-based; -1 disables
   // an injection. abort_beat >= 0 resets the DUT when that beat is presented.
   task automatic run_fill(input logic [ADDR_W-1:0] addr, input bit fixed_words,
                           input int ar_delay, input bit gaps,
                           input int resp_beat, input int rid_beat, input int rlast_beat,
                           input int flush_beat, input bit flush_req, input bit flush_wr,
                           input bit hold_miss, input int abort_beat, input bit abort_sync);
      logic [XLEN-1:0]   words [NB];
      logic [LINE_W-1:0] exp_line;
      logic [ADDR_W-1:0] exp_addr;
      bit                exp_err, exp_flush;
      int                beat, cyc;
      exp_line = '0;
      for (int i = 0; i < NB; i++) begin
         words[i] = fixed_words ? XLEN'(32'h11 * (i + 1)) : $urandom;
         exp_line[i*XLEN +: XLEN] = words[i];
      end
      exp_addr  = (addr / (LINE_W / 8)) * (LINE_W / 8);
      exp_err   = (resp_beat >= 0) || (rid_beat >= 0) || (rlast_beat >= 0);
      exp_flush = (flush_beat >= 0) || flush_req || flush_wr;

      @(negedge aclk);
      drive_idle();
      miss_valid = 1'b1;
      miss_addr  = addr;
      #1 check_b("miss_ready_idle", miss_ready, 1'b1);

      for (int d = 0; d <= ar_delay; d++) begin
         @(negedge aclk);
         drive_idle();
         miss_valid = hold_miss;
         miss_addr  = $urandom;
         arready    = (d == ar_delay);
         flush      = flush_req && (d == 0);
         #1;
         check_b("ar_valid", arvalid, 1'b1);
         check("ar_addr", LINE_W'(araddr), LINE_W'(exp_addr));
         check_b("ar_miss_ready", miss_ready, 1'b0);
         check_b("ar_rready", rready, 1'b0);
         if (d == 0) begin
            check("ar_len",   LINE_W'(arlen),   LINE_W'(NB - 1));
            check("ar_size",  LINE_W'(arsize),  LINE_W'(2));
            check("ar_burst", LINE_W'(arburst), LINE_W'(1));
            check("ar_id",    LINE_W'(arid),    LINE_W'(ID));
         end
      end

      beat = 0;
      cyc  = 0;
      while (beat < NB) begin
         @(negedge aclk);
         drive_idle();
         miss_valid = hold_miss;
         rvalid     = gaps ? cyc[0] : 1'b1;
         cyc++;
         if (rvalid) begin
            rdata = words[beat];
            rresp = (beat == resp_beat) ? 2'b10 : 2'b00;
            rid   = (beat == rid_beat) ? (ID ^ 8'h01) : ID;
            rlast = (beat == NB - 1) ^ (beat == rlast_beat);
            flush = (beat == flush_beat);
         end else begin
            rdata = $urandom;
         end
         if (rvalid && beat == abort_beat) begin
            if (abort_sync) begin
               srst = 1'b1;
               @(negedge aclk);
               srst = 1'b0;
               drive_idle();
               #1 check_reset_outputs("srst_mid");
            end else begin
               arst = 1'b1;
               #1 check_reset_outputs("arst_mid");
               @(negedge aclk);
               arst = 1'b0;
               drive_idle();
            end
            return;
         end
         #1;
         check_b("fill_rready", rready, 1'b1);
         check_b("fill_arvalid", arvalid, 1'b0);
         check_b("fill_no_wen", cache_wen, 1'b0);
         check_b("fill_no_done", fill_done, 1'b0);
         if (rvalid) beat++;
      end

      @(negedge aclk);
      drive_idle();
      flush = flush_wr;
      #1;
      check_b("wr_fill_done", fill_done, 1'b1);
      check_b("wr_fill_err", fill_err, exp_err);
      check_b("wr_cache_wen", cache_wen, !exp_err && !exp_flush);
      check("wr_waddr", LINE_W'(cache_waddr), LINE_W'(exp_addr));
      check("wr_wdata", cache_wdata, exp_line);
      check_b("wr_miss_ready", miss_ready, 1'b0);
      check_b("wr_rready", rready, 1'b0);

      @(negedge aclk);
      drive_idle();
      #1;
      check_b("post_miss_ready", miss_ready, 1'b1);
      check_b("post_fill_done", fill_done, 1'b0);
      check_b("post_cache_wen", cache_wen, 1'b0);
      check("post_waddr_held", LINE_W'(cache_waddr), LINE_W'(exp_addr));
      check("post_wdata_held", cache_wdata, exp_line);
   endtask

   initial begin
      int mode, pick;
      n_cmp = 0;
      n_mis = 0;
      drive_idle();
      miss_addr = '0;
      srst = 1'b0;
      arst = 1'b1;
      repeat (3) @(negedge aclk);
      #1 check_reset_outputs("por");
      arst = 1'b0;

      // Scenario 1: zero-wait memory, fixed data
      run_fill(32'h0000_100C, 1, 0, 0, -1, -1, -1, -1, 0, 0, 0, -1, 0);
      check("s1_waddr", LINE_W'(cache_waddr), LINE_W'(32'h0000_1000));
      check("s1_wdata", cache_wdata, 128'h00000044_00000033_00000022_00000011);

      // Scenario 2: arready after 5 cycles, rvalid every other cycle, miss held
      run_fill($urandom, 0, 5, 1, -1, -1, -1, -1, 0, 0, 1, -1, 0);
      // Scenario 3: SLVERR on beat 2
      run_fill($urandom, 0, 0, 0, 1, -1, -1, -1, 0, 0, 0, -1, 0);
      // Scenario 4: flush during beat 1, then a normal fill at 0x2000
      run_fill($urandom, 0, 0, 0, -1, -1, -1, 0, 0, 0, 0, -1, 0);
      run_fill(32'h0000_2000, 0, 0, 0, -1, -1, -1, -1, 0, 0, 0, -1, 0);
      check("s4_next_waddr", LINE_W'(cache_waddr), LINE_W'(32'h0000_2000));
      // Scenario 5: async reset during beat 3, then a clean fill
      run_fill($urandom, 0, 1, 0, -1, -1, -1, -1, 0, 0, 0, 2, 0);
      run_fill($urandom, 0, 0, 0, -1, -1, -1, -1, 0, 0, 0, -1, 0);
      // Scenario 6: early rlast on beat 2
      run_fill($urandom, 0, 0, 0, -1, -1, 1, -1, 0, 0, 0, -1, 0);

      // Flush in REQ, flush coincident with WRITE, wrong RID, sync reset mid-burst
      run_fill($urandom, 0, 2, 0, -1, -1, -1, -1, 1, 0, 0, -1, 0);
      run_fill($urandom, 0, 0, 0, -1, -1, -1, -1, 0, 1, 0, -1, 0);
      run_fill($urandom, 0, 0, 1, -1, 3, -1, -1, 0, 0, 0, -1, 0);
      run_fill($urandom, 0, 0, 0, -1, -1, -1, -1, 0, 0, 0, 1, 1);

      // Flush while idle leaves the next fill untouched
      @(negedge aclk);
      drive_idle();
      flush = 1'b1;
      #1 check_b("idle_flush_ready", miss_ready, 1'b1);
      run_fill($urandom, 0, 0, 0, -1, -1, -1, -1, 0, 0, 0, -1, 0);

      for (int n = 0; n < 24; n++) begin
         mode = $urandom_range(0, 6);
         pick = $urandom_range(0, NB - 1);
         run_fill($urandom, 0, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  (mode == 1) ? pick : -1, (mode == 2) ? pick : -1,
                  (mode == 3) ? pick : -1, (mode == 4) ? pick : -1,
                  mode == 5, mode == 6, 1'($urandom_range(0, 1)), -1, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/friscv_icache_filler.md
FRISCV_ICACHE_FILLER -- requirements
Module: friscv_icache_filler

Interface
REQ-001 Parameters, one per line: XLEN 32, instruction/AXI data width; ADDR_W 32, address width; CACHE_LINE_W 128, line payload bits; AXI_ID_W 8, ID width; AXI_ID 0x10, fixed ARID.
REQ-002 One clock, aclk; reset asynchronous active-high, arst; all ports listed below.
REQ-003 aclk in 1: clock; arst in 1: async active-high reset; srst in 1: sync reset, active-high.
REQ-004 flush in 1: FENCE.i flush pulse; miss_valid in 1 / miss_ready out 1 / miss_addr in ADDR_W: fill request handshake.
REQ-005 arvalid out 1 / arready in 1 / araddr out ADDR_W / arlen out 8 / arsize out 3 / arburst out 2 / arid out AXI_ID_W: AXI4 read address.
REQ-006 rvalid in 1 / rready out 1 / rdata in XLEN / rresp in 2 / rlast in 1 / rid in AXI_ID_W: AXI4 read data.
REQ-007 cache_wen out 1 / cache_waddr out ADDR_W / cache_wdata out CACHE_LINE_W: line write port to the cache line storage.
REQ-008 fill_done out 1 / fill_err out 1: one-cycle completion pulses.

Function
REQ-009 NB_BEATS = CACHE_LINE_W/XLEN; line alignment = log2(CACHE_LINE_W/8) address LSBs.
REQ-010 FSM states: IDLE, REQ, FILL, WRITE; IDLE after reset.
REQ-011 miss_ready = 1 only in IDLE; transfer when miss_valid && miss_ready; the address is captured line-aligned (offset bits cleared).
REQ-012 IDLE -> REQ on transfer; arvalid asserts the next cycle and stays high with stable payload until arready.
REQ-013 araddr = aligned address; arlen = NB_BEATS-1; arsize = log2(XLEN/8); arburst = INCR (2'b01); arid = AXI_ID.
REQ-014 REQ -> FILL on arvalid && arready; rready = 1 only in FILL.
REQ-015 In FILL, each rvalid && rready beat stores rdata at bit slice [beat_cnt*XLEN +: XLEN] and increments the beat counter (width log2(NB_BEATS)+1, cleared on entry to REQ).
REQ-016 FILL -> WRITE when the NB_BEATS-th beat is accepted; rlast is checked but not used for the transition.
REQ-017 The error flag sets when any beat has rresp != 2'b00, rid != AXI_ID, or rlast mismatches (1 before the final beat, or 0 on it); it is cleared on entry to REQ.
REQ-018 WRITE lasts exactly one cycle, then returns to IDLE; fill_done = 1 in that cycle.
REQ-019 In WRITE, cache_wen = 1 iff error flag = 0 and no flush was seen since the miss was accepted; fill_err = error flag.
REQ-020 cache_waddr = captured aligned address and cache_wdata = assembled line, both held stable from WRITE until the next accepted miss.
REQ-021 Latency with zero-wait memory: miss accepted at cycle 0, arvalid at cycle 1, beats at cycles 2..NB_BEATS+1, cache_wen at cycle NB_BEATS+2.
REQ-022 Flush in REQ or FILL does not abort the AXI transaction; all beats are drained and the write is suppressed, with fill_done still pulsing. Flush coincident with the WRITE cycle also suppresses cache_wen.
REQ-023 Flush in IDLE has no effect on the filler.
REQ-024 miss_valid held during a fill is ignored until return to IDLE; the next transfer is possible in the cycle after WRITE.

Reset
REQ-025 On arst (async) or srst (sync), the state is IDLE and the counter, error flag and flush flag are cleared.
REQ-026 On arst or srst, outputs are: miss_ready 1, arvalid 0, rready 0, cache_wen 0, fill_done 0, fill_err 0, araddr/cache_waddr/cache_wdata 0.
REQ-027 Reset mid-fill abandons the burst; the memory side is expected to be reset by the same reset.

Structure
REQ-028 friscv_icache_pkg holds the FSM state enum, the AXI burst/resp constants (INCR, OKAY) and the NB_BEATS/offset-width localparam functions.
REQ-029 Single module; no sub-module. Beat assembly stays inline.

Verification
REQ-030 Scenario 1: miss_addr 0x0000_100C, zero-wait memory returning 0x11,0x22,0x33,0x44 -> araddr 0x1000, arlen 3, cache_wen at cycle 6, cache_wdata 0x00000044_00000033_00000022_00000011.
REQ-031 Scenario 2: arready delayed 5 cycles, rvalid toggling every other cycle -> arvalid/araddr stable, beats in order, exactly one cache_wen.
REQ-032 Scenario 3: rresp 2'b10 on beat 2 -> all 4 beats drained, fill_done with fill_err 1, cache_wen 0.
REQ-033 Scenario 4: flush pulse during beat 1 -> fill_done 1, fill_err 0, cache_wen 0; a following miss at 0x2000 is written normally.
REQ-034 Scenario 5: arst asserted during beat 3 -> outputs at reset values immediately, miss_ready 1; a new fill after release completes correctly.
REQ-035 Scenario 6: rlast on beat 2 of 4 -> fill_err 1, no write.
